// File: rtl/fetch_queue.sv
// Instruction fetch queue between fetch/branch prediction and decode.
// Holds {pc, instr, pred_pc, pred_valid} per instruction in program order.
// A flush from an EX redirect discards every entry in the queue.
// Optional feature: define FETCHQ_BYPASS_EN to forward an enqueue straight to
// the dequeue port in the same cycle when the queue is empty.
module fetch_queue #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned PC_W    = 48,
  parameter int unsigned INSTR_W = 32
) (
  input  logic                     clk,
  input  logic                     n_reset,
  input  logic                     flush,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  input  logic [PC_W-1:0]          enq_pc,
  input  logic [INSTR_W-1:0]       enq_instr,
  input  logic [PC_W-1:0]          enq_pred_pc,
  input  logic                     enq_pred_valid,
  output logic                     deq_valid,
  input  logic                     deq_ready,
  output logic [PC_W-1:0]          deq_pc,
  output logic [INSTR_W-1:0]       deq_instr,
  output logic [PC_W-1:0]          deq_pred_pc,
  output logic                     deq_pred_valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] DepthVal = PW'(DEPTH);

  // Payload storage; deliberately not reset, validity comes from the pointers.
  logic [PC_W-1:0]    pc_mem        [DEPTH];
  logic [INSTR_W-1:0] instr_mem     [DEPTH];
  logic [PC_W-1:0]    pred_pc_mem   [DEPTH];
  logic               pred_valid_mem[DEPTH];

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_idx, wr_idx;

  logic empty, full;
  logic enq_fire, deq_fire;
  logic wr_en, rd_adv;

  assign rd_idx = rd_ptr_q[AW-1:0];
  assign wr_idx = wr_ptr_q[AW-1:0];

  // Occupancy flags derived purely from registered pointers.
  always_comb begin
    empty = (rd_ptr_q == wr_ptr_q);
    full  = (rd_ptr_q[AW-1:0] == wr_ptr_q[AW-1:0]) && (rd_ptr_q[AW] != wr_ptr_q[AW]);
  end

  assign enq_ready = !full;
  assign count     = wr_ptr_q - rd_ptr_q;

`ifdef FETCHQ_BYPASS_EN
  logic bypass;

  // Empty queue forwards the incoming instruction directly to decode.
  always_comb begin
    bypass    = empty && enq_valid && !flush;
    deq_valid = (!empty || bypass) && !flush;
    if (bypass) begin
      deq_pc         = enq_pc;
      deq_instr      = enq_instr;
      deq_pred_pc    = enq_pred_pc;
      deq_pred_valid = enq_pred_valid;
    end else begin
      deq_pc         = pc_mem[rd_idx];
      deq_instr      = instr_mem[rd_idx];
      deq_pred_pc    = pred_pc_mem[rd_idx];
      deq_pred_valid = pred_valid_mem[rd_idx];
    end
    enq_fire = enq_valid && enq_ready && !flush;
    deq_fire = deq_valid && deq_ready;
    // A bypassed entry taken by decode never touches storage or pointers.
    wr_en    = enq_fire && !(bypass && deq_ready);
    rd_adv   = deq_fire && !bypass;
  end
`else
  // Head entry drives decode; flush hides it for the redirect cycle.
  always_comb begin
    deq_valid      = !empty && !flush;
    deq_pc         = pc_mem[rd_idx];
    deq_instr      = instr_mem[rd_idx];
    deq_pred_pc    = pred_pc_mem[rd_idx];
    deq_pred_valid = pred_valid_mem[rd_idx];
    enq_fire       = enq_valid && enq_ready && !flush;
    deq_fire       = deq_valid && deq_ready;
    wr_en          = enq_fire;
    rd_adv         = deq_fire;
  end
`endif

  // Next-state pointers; flush dominates and rewinds both to zero.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (wr_en)  wr_ptr_d = wr_ptr_q + PW'(1);
      if (rd_adv) rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  // Pointer registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Payload write at the tail.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem[wr_idx]         <= enq_pc;
      instr_mem[wr_idx]      <= enq_instr;
      pred_pc_mem[wr_idx]    <= enq_pred_pc;
      pred_valid_mem[wr_idx] <= enq_pred_valid;
    end
  end

  a_no_enq_when_full: assert property (@(posedge clk) disable iff (!n_reset)
    wr_en |-> !full);
  a_no_deq_when_empty: assert property (@(posedge clk) disable iff (!n_reset)
    rd_adv |-> !empty);
  a_count_bound: assert property (@(posedge clk) disable iff (!n_reset)
    count <= DepthVal);

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized
// traffic compared every cycle against a queue-based reference model.
module tb_fetch_queue;

  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [47:0] pc;
    logic [31:0] instr;
    logic [47:0] pred_pc;
    logic        pred_valid;
  } ent_t;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        flush, enq_valid, enq_ready, enq_pred_valid;
  logic [47:0] enq_pc, enq_pred_pc;
  logic [31:0] enq_instr;
  logic        deq_valid, deq_ready, deq_pred_valid;
  logic [47:0] deq_pc, deq_pred_pc;
  logic [31:0] deq_instr;
  logic [2:0]  count;

  int checks = 0;
  int failures = 0;

  ent_t        mq[$];
  logic [47:0] deq_log[$];

  fetch_queue #(.DEPTH(DEPTH), .PC_W(48), .INSTR_W(32)) dut (
    .clk(clk), .n_reset(n_reset), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_pc(enq_pc),
    .enq_instr(enq_instr), .enq_pred_pc(enq_pred_pc), .enq_pred_valid(enq_pred_valid),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_pc(deq_pc),
    .deq_instr(deq_instr), .deq_pred_pc(deq_pred_pc), .deq_pred_valid(deq_pred_valid),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: outputs from queue contents, updated on each rising edge.
  ent_t head, m_new;
  logic exp_dv, m_flush, m_deq, m_enq, m_take;
  always begin
    @(negedge clk);
    #2;
    m_flush = 1'b0; m_deq = 1'b0; m_enq = 1'b0; m_take = 1'b0;
    if (!n_reset) begin
      mq.delete();
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_deq_valid", 64'(deq_valid), 64'd0);
      chk("rst_enq_ready", 64'(enq_ready), 64'd1);
    end else begin
      m_new = '{pc: enq_pc, instr: enq_instr, pred_pc: enq_pred_pc,
                pred_valid: enq_pred_valid};
      head  = (mq.size() > 0) ? mq[0] : m_new;
      exp_dv = (mq.size() > 0) && !flush;
`ifdef FETCHQ_BYPASS_EN
      if (mq.size() == 0 && enq_valid && !flush) begin
        exp_dv = 1'b1;
        m_take = deq_ready;
      end
`endif
      chk("count", 64'(count), 64'(mq.size()));
      chk("enq_ready", 64'(enq_ready), 64'(mq.size() < DEPTH));
      chk("deq_valid", 64'(deq_valid), 64'(exp_dv));
      if (exp_dv) begin
        chk("deq_pc", 64'(deq_pc), 64'(head.pc));
        chk("deq_instr", 64'(deq_instr), 64'(head.instr));
        chk("deq_pred_pc", 64'(deq_pred_pc), 64'(head.pred_pc));
        chk("deq_pred_valid", 64'(deq_pred_valid), 64'(head.pred_valid));
      end
      if (deq_valid && deq_ready) deq_log.push_back(deq_pc);
      m_flush = flush;
      m_deq   = exp_dv && deq_ready;
      m_enq   = enq_valid && (mq.size() < DEPTH) && !flush;
    end
    @(posedge clk);
    if (!n_reset) mq.delete();
    else if (m_flush) mq.delete();
    else if (!m_take) begin
      if (m_deq) void'(mq.pop_front());
      if (m_enq) mq.push_back(m_new);
    end
  end

  task automatic drive(input logic fl, input logic ev, input logic [47:0] pc, input logic dr);
    flush          = fl;
    enq_valid      = ev;
    enq_pc         = pc;
    enq_instr      = $urandom;
    enq_pred_pc    = {16'($urandom), 32'($urandom)};
    enq_pred_valid = 1'($urandom);
    deq_ready      = dr;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    n_reset = 1'b0;
    drive(1'b0, 1'b0, 48'h0, 1'b0);
    tick(); tick();
    #4;
    chk("reset_count_lit", 64'(count), 64'd0);
    chk("reset_enq_ready_lit", 64'(enq_ready), 64'd1);
    tick();
    n_reset = 1'b1;
    tick();

    // Fill with decode stalled, then drain in order.
    deq_log.delete();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 48'h1000 + 48'(4 * i), 1'b0);
      tick();
    end
    drive(1'b0, 1'b0, 48'h0, 1'b0);
    #4;
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_enq_ready", 64'(enq_ready), 64'd0);
    chk("fill_head_pc", 64'(deq_pc), 64'h1000);
    tick();
    drive(1'b0, 1'b0, 48'h0, 1'b1);
    repeat (4) tick();
    drive(1'b0, 1'b0, 48'h0, 1'b0);
    #4;
    chk("drain_count", 64'(count), 64'd0);
    chk("drain_n", 64'(deq_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < deq_log.size(); i++)
      chk("drain_order", 64'(deq_log[i]), 64'h1000 + 64'(4 * i));
    tick();

    // Streaming through the wrap point.
    deq_log.delete();
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b1, 48'h4000 + 48'(4 * i), 1'b1);
      #4;
      chk("stream_count_le1", 64'(count <= 3'd1), 64'd1);
      tick();
    end
    drive(1'b0, 1'b0, 48'h0, 1'b1);
    tick(); tick();
    chk("stream_n", 64'(deq_log.size()), 64'd20);
    for (int i = 0; i < 20 && i < deq_log.size(); i++)
      chk("stream_order", 64'(deq_log[i]), 64'h4000 + 64'(4 * i));

    // Full with enq and deq together: only the dequeue happens.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 48'h6000 + 48'(4 * i), 1'b0);
      tick();
    end
    deq_log.delete();
    drive(1'b0, 1'b1, 48'h5000, 1'b1);
    tick();
    drive(1'b0, 1'b0, 48'h0, 1'b0);
    #4;
    chk("full_deq_count", 64'(count), 64'd3);
    chk("full_deq_n", 64'(deq_log.size()), 64'd1);
    tick();
    drive(1'b0, 1'b0, 48'h0, 1'b1);
    repeat (3) tick();
    drive(1'b0, 1'b0, 48'h0, 1'b0);
    chk("full_deq_total", 64'(deq_log.size()), 64'd4);
    if (deq_log.size() == 4) chk("full_deq_last", 64'(deq_log[3]), 64'h600C);
    tick();

    // Flush with an enqueue in the same cycle.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 48'h7000 + 48'(4 * i), 1'b0);
      tick();
    end
    drive(1'b1, 1'b1, 48'hDEAD, 1'b1);
    #4;
    chk("flush_deq_valid_masked", 64'(deq_valid), 64'd0);
    tick();
    drive(1'b0, 1'b0, 48'h0, 1'b0);
    #4;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_deq_valid", 64'(deq_valid), 64'd0);
    tick();
    deq_log.delete();
    drive(1'b0, 1'b1, 48'h2000, 1'b1);
    tick();
    drive(1'b0, 1'b0, 48'h0, 1'b1);
    tick(); tick();
    chk("post_flush_n", 64'(deq_log.size()), 64'd1);
    if (deq_log.size() > 0) chk("post_flush_pc", 64'(deq_log[0]), 64'h2000);

`ifdef FETCHQ_BYPASS_EN
    drive(1'b0, 1'b1, 48'h3000, 1'b1);
    enq_pred_pc = 48'h3100;
    #4;
    chk("byp_deq_valid", 64'(deq_valid), 64'd1);
    chk("byp_deq_pc", 64'(deq_pc), 64'h3000);
    chk("byp_deq_pred_pc", 64'(deq_pred_pc), 64'h3100);
    tick();
    drive(1'b0, 1'b0, 48'h0, 1'b0);
    #4;
    chk("byp_count", 64'(count), 64'd0);
    tick();
`endif

    // Randomized traffic with occasional flush and mid-run reset.
    for (int i = 0; i < 3000; i++) begin
      n_reset = ($urandom_range(0, 199) != 0);
      drive($urandom_range(0, 99) < 5, $urandom_range(0, 99) < 70,
            {16'($urandom), 32'($urandom)}, $urandom_range(0, 99) < 55);
      tick();
    end
    n_reset = 1'b1;
    drive(1'b0, 1'b0, 48'h0, 1'b0);
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
